// File: rtl/mult_share_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter that time-shares one multiplier.
package mult_share_arbiter_pkg;
  localparam int N_REQ_DEF = 4;
  localparam int W_DEF     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } state_t;
endpackage

// File: rtl/multiplier_4_bit.sv
// Combinational unsigned multiplier; full-width product, no truncation.
module multiplier_4_bit #(
  parameter int W = 4
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] mul_result
);
  assign mul_result = {{W{1'b0}}, a} * {{W{1'b0}}, b};
endmodule

// File: rtl/mult_share_arbiter.sv
// N_REQ requesters share a single multiplier; round-robin grant in IDLE,
// one-cycle multiply, then the result is held in RESP until accepted.
module mult_share_arbiter
  import mult_share_arbiter_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int W     = W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*W-1:0]       req_a,
  input  logic [N_REQ*W-1:0]       req_b,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     rsp_valid,
  output logic [2*W-1:0]           rsp_data,
  output logic [$clog2(N_REQ)-1:0] rsp_id,
  input  logic                     rsp_ready,
  output logic                     busy,
  output logic [15:0]              op_count
);
  localparam int ID_W = $clog2(N_REQ);

  state_t          state_q, state_d;
  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] id_q;
  logic [W-1:0]    a_q, b_q;
  logic [2*W-1:0]  rsp_data_q;
  logic [2*W-1:0]  mul_result;
  logic [15:0]     op_count_q;
  logic            found;
  logic [ID_W-1:0] grant_id;

  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] id);
    if (int'(id) == N_REQ - 1) return '0;
    else return id + 1'b1;
  endfunction

  // Round-robin pick: first valid index at or after ptr, wrapping to 0.
  always_comb begin
    int              idx;
    logic [ID_W-1:0] cand;
    found    = 1'b0;
    grant_id = '0;
    idx      = 0;
    cand     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      cand = ID_W'(idx);
      if (!found && req_valid[cand]) begin
        found    = 1'b1;
        grant_id = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          req_ready[grant_id] = 1'b1;
          state_d             = MUL;
        end
      end
      MUL:     state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (rst) req_ready = '0;
  end

  multiplier_4_bit #(.W(W)) u_mul (
    .a          (a_q),
    .b          (b_q),
    .mul_result (mul_result)
  );

  // Capture at grant, multiply in MUL, retire on the response handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      id_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rsp_data_q <= '0;
      op_count_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (found) begin
            a_q  <= req_a[grant_id*W +: W];
            b_q  <= req_b[grant_id*W +: W];
            id_q <= grant_id;
          end
        end
        MUL: rsp_data_q <= mul_result;
        RESP: begin
          if (rsp_ready) begin
            ptr_q      <= next_ptr(id_q);
            op_count_q <= op_count_q + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = !rst && (state_q == RESP);
  assign busy      = !rst && (state_q != IDLE);
  assign rsp_id    = rst ? '0 : id_q;
  assign rsp_data  = rsp_data_q;
  assign op_count  = op_count_q;
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: directed vector table, corner sequences and a
// randomized run against a transaction-level round-robin model.
module tb_mult_share_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [15:0] req_a, req_b;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic [1:0]  rsp_id;
  logic        rsp_ready;
  logic        busy;
  logic [15:0] op_count;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int exp_cnt = 0;

  localparam logic [15:0] A_LANES = 16'h4321;  // a_i = i+1
  localparam logic [15:0] B_LANES = 16'h5432;  // b_i = i+2

  typedef struct {
    logic [3:0]  vld;
    logic [15:0] a;
    logic [15:0] b;
    int          exp_id;
    int          exp_data;
  } vec_t;

  vec_t vecs[7];

  mult_share_arbiter #(.N_REQ(4), .W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_ready (rsp_ready),
    .busy      (busy),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int rr_pick(input logic [3:0] v, input int p);
    int idx;
    for (int k = 0; k < 4; k++) begin
      idx = (p + k) % 4;
      if (v[idx[1:0]]) return idx;
    end
    return -1;
  endfunction

  function automatic int lane(input logic [15:0] x, input int i);
    return int'((x >> (4 * i)) & 16'h000F);
  endfunction

  // Ends at posedge+1 with rst low and the DUT idle.
  task automatic do_reset();
    rst = 1'b1; req_valid = 4'hF; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    @(negedge clk);
    check("rst req_ready", req_ready, 0);
    check("rst rsp_valid", rsp_valid, 0);
    check("rst busy", busy, 0);
    check("rst rsp_id", rsp_id, 0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0; req_valid = '0;
    exp_cnt = 0;
    @(negedge clk);
    check("rst op_count", op_count, 0);
    check("rst idle busy", busy, 0);
    @(posedge clk); #1;
  endtask

  // Called at posedge+1; returns at posedge+1 just after the response handshake.
  task automatic run_op(input string tag, input logic [3:0] vld, input logic [15:0] a,
                        input logic [15:0] b, input bit keep, input int hold,
                        input int exp_id, input int exp_data, output int tg);
    int n;
    req_valid = vld; req_a = a; req_b = b; rsp_ready = (hold == 0);
    n = 0;
    @(negedge clk);
    while (req_ready == 4'b0 && n < 20) begin n++; @(negedge clk); end
    check({tag, " grant"}, req_ready, 32'(1) << exp_id);
    check({tag, " count_pre"}, op_count, exp_cnt);
    tg = cyc;
    if (!keep) begin @(posedge clk); #1; req_valid = '0; end
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 20) begin
      check({tag, " ready_in_mul"}, req_ready, 0);
      check({tag, " busy_in_mul"}, busy, 1);
      n++;
      @(negedge clk);
    end
    check({tag, " latency"}, cyc - tg, 2);
    check({tag, " data"}, rsp_data, exp_data);
    check({tag, " id"}, rsp_id, exp_id);
    for (int h = 1; h < hold; h++) begin
      @(posedge clk); #1; req_valid = 4'hF;
      @(negedge clk);
      check({tag, " hold valid"}, rsp_valid, 1);
      check({tag, " hold data"}, rsp_data, exp_data);
      check({tag, " hold id"}, rsp_id, exp_id);
      check({tag, " hold ready"}, req_ready, 0);
      check({tag, " hold count"}, op_count, exp_cnt);
    end
    if (hold > 0) begin
      @(posedge clk); #1; rsp_ready = 1'b1; req_valid = keep ? vld : 4'b0;
      @(negedge clk);
      check({tag, " release valid"}, rsp_valid, 1);
      check({tag, " release ready"}, req_ready, 0);
    end
    @(posedge clk); #1;
    exp_cnt = (exp_cnt + 1) & 16'hFFFF;
    check({tag, " count_post"}, op_count, exp_cnt);
    check({tag, " valid_drop"}, rsp_valid, 0);
  endtask

  initial begin
    int tg, prev_tg;
    int m_ptr, m_cnt, phase, w, e_id, e_data;
    logic [3:0] v;

    vecs[0] = '{4'b0001, 16'h0003, 16'h0005, 0, 15};
    vecs[1] = '{4'b0100, 16'h0F00, 16'h0F00, 2, 225};
    vecs[2] = '{4'b0001, 16'h0000, 16'h0009, 0, 0};
    vecs[3] = '{4'b1111, A_LANES, B_LANES, 1, 6};
    vecs[4] = '{4'b1001, A_LANES, B_LANES, 3, 20};
    vecs[5] = '{4'b1010, A_LANES, B_LANES, 1, 6};
    vecs[6] = '{4'b0011, A_LANES, B_LANES, 0, 2};

    do_reset();
    for (int i = 0; i < 7; i++)
      run_op($sformatf("vec%0d", i), vecs[i].vld, vecs[i].a, vecs[i].b, 1'b0, 0,
             vecs[i].exp_id, vecs[i].exp_data, tg);

    // All requesters valid continuously: fair rotation, one grant per 3 cycles.
    do_reset();
    prev_tg = 0;
    for (int i = 0; i < 5; i++) begin
      run_op($sformatf("rr%0d", i), 4'hF, A_LANES, B_LANES, 1'b1, 0,
             i % 4, ((i % 4) + 1) * ((i % 4) + 2), tg);
      if (i > 0) check("rr spacing", tg - prev_tg, 3);
      prev_tg = tg;
    end
    req_valid = '0;

    // Only requester 3 valid from ptr 0, then the pointer wraps back to 0.
    do_reset();
    run_op("only3", 4'b1000, 16'h5000, 16'h3000, 1'b0, 0, 3, 15, tg);
    run_op("wrap", 4'b1111, A_LANES, B_LANES, 1'b0, 0, 0, 2, tg);
    run_op("hold5", 4'b0001, 16'h0006, 16'h0007, 1'b0, 5, 0, 42, tg);

    // Reset while an operation sits in MUL.
    do_reset();
    run_op("pre", 4'b0100, A_LANES, B_LANES, 1'b0, 0, 2, 12, tg);
    req_valid = 4'b0010; req_a = 16'h0070; req_b = 16'h0070; rsp_ready = 1'b1;
    @(negedge clk);
    check("abort grant", req_ready, 4'b0010);
    @(posedge clk); #1; rst = 1'b1; req_valid = '0;
    @(negedge clk);
    check("abort rst valid", rsp_valid, 0);
    check("abort rst busy", busy, 0);
    @(posedge clk); #1; rst = 1'b0; exp_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort no rsp", rsp_valid, 0);
      check("abort count", op_count, 0);
    end
    @(posedge clk); #1;
    run_op("after_abort", 4'b1110, A_LANES, B_LANES, 1'b0, 0, 1, 6, tg);

    // Randomized traffic against a transaction-level model.
    do_reset();
    m_ptr = 0; m_cnt = 0; phase = 0; e_id = 0; e_data = 0;
    for (int c = 0; c < 400; c++) begin
      v = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) v = 4'b0;
      req_valid = v;
      req_a = 16'($urandom);
      req_b = 16'($urandom);
      rsp_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      w = (phase == 0) ? rr_pick(req_valid, m_ptr) : -1;
      check("rnd ready", req_ready, (w < 0) ? 0 : (32'(1) << w));
      check("rnd valid", rsp_valid, (phase == 2) ? 1 : 0);
      check("rnd busy", busy, (phase != 0) ? 1 : 0);
      check("rnd count", op_count, m_cnt);
      if (phase == 2) begin
        check("rnd data", rsp_data, e_data);
        check("rnd id", rsp_id, e_id);
      end
      if (phase == 0 && w >= 0) begin
        e_id = w;
        e_data = lane(req_a, w) * lane(req_b, w);
        phase = 1;
      end else if (phase == 1) begin
        phase = 2;
      end else if (phase == 2 && rsp_ready) begin
        m_cnt = (m_cnt + 1) & 16'hFFFF;
        m_ptr = (e_id + 1) % 4;
        phase = 0;
      end
      @(posedge clk); #1;
    end
    req_valid = '0;
    rsp_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
